// File: rtl/memory_v2.sv
// 2^K x M register-file RAM: one synchronous write port shared with read port 1,
// an independent read-only port 2, and a synchronous clear of the whole array.
module memory_v2 #(
  parameter int M = 8,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] Min,
  input  logic         we,
  input  logic [K-1:0] addr1,
  input  logic [K-1:0] addr2,
  output logic [M-1:0] Mout1,
  output logic [M-1:0] Mout2
);

  localparam int DEPTH = 1 << K;

  logic [M-1:0] mem_q [DEPTH];
  logic [M-1:0] mem_d [DEPTH];

  // NOTE: mem_d starts as a copy of mem_q so every path assigns it and no latch is inferred.
  always_comb begin
    mem_d = mem_q;
    if (rst) begin
      // Clear wins over a simultaneous write.
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
    end else if (we) begin
      mem_d[addr1] = Min;
    end
  end

  // NOTE: the array is cleared through mem_d rather than a reset branch here, because the clear is
  // a functional feature of this block, not just power-up initialisation.
  // NOTE: state updates use non-blocking assignments so all words update together at the edge.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Read ports are purely combinational; a write becomes visible only after the edge.
  assign Mout1 = mem_q[addr1];
  assign Mout2 = mem_q[addr2];

endmodule

// File: tb/tb_memory_v2.sv
// Directed bench for memory_v2: stimulus pushes expected read values into a scoreboard
// queue and a separate monitor samples the read ports and compares.
module tb_memory_v2;

  localparam int M = 8;
  localparam int K = 4;

  logic         clk;
  logic         rst;
  logic [M-1:0] Min;
  logic         we;
  logic [K-1:0] addr1;
  logic [K-1:0] addr2;
  logic [M-1:0] Mout1;
  logic [M-1:0] Mout2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string        name;
    logic [M-1:0] exp1;
    logic [M-1:0] exp2;
    bit           chk1;
    bit           chk2;
  } exp_t;

  exp_t exp_q[$];

  memory_v2 #(.M(M), .K(K)) dut (
    .Mout1 (Mout1),
    .Mout2 (Mout2),
    .Min   (Min),
    .we    (we),
    .clk   (clk),
    .addr1 (addr1),
    .addr2 (addr2),
    .rst   (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Queue the expected outputs for the current inputs and give the monitor time to sample.
  task automatic expect_out(input string name, input logic [M-1:0] e1, input logic [M-1:0] e2,
                            input bit c1, input bit c2);
    exp_t it;
    it.name = name;
    it.exp1 = e1;
    it.exp2 = e2;
    it.chk1 = c1;
    it.chk2 = c2;
    exp_q.push_back(it);
    #2;
  endtask

  task automatic write_word(input logic [K-1:0] a, input logic [M-1:0] d);
    @(negedge clk);
    we    = 1'b1;
    addr1 = a;
    Min   = d;
    @(posedge clk);
    @(negedge clk);
    we    = 1'b0;
  endtask

  // Monitor: samples the combinational read ports shortly after each expectation arrives.
  initial begin
    exp_t it;
    forever begin
      wait (exp_q.size() != 0);
      #1;
      it = exp_q.pop_front();
      if (it.chk1) check({it.name, "/Mout1"}, Mout1, it.exp1);
      if (it.chk2) check({it.name, "/Mout2"}, Mout2, it.exp2);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    we    = 1'b0;
    Min   = '0;
    addr1 = '0;
    addr2 = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Every word reads zero after the clear.
    for (int a = 0; a < 16; a++) begin
      addr1 = K'(a);
      addr2 = K'(15 - a);
      #1;
      expect_out($sformatf("reset_scan_%0d", a), 8'h00, 8'h00, 1'b1, 1'b1);
    end

    write_word(4'd7, 8'd127);
    #1;
    expect_out("write7_port1", 8'd127, 8'h00, 1'b1, 1'b0);
    addr2 = 4'd7;
    #1;
    expect_out("write7_same_addr", 8'd127, 8'd127, 1'b1, 1'b1);

    write_word(4'd8, 8'd255);
    addr1 = 4'd7;
    addr2 = 4'd8;
    #1;
    expect_out("two_words", 8'd127, 8'd255, 1'b1, 1'b1);
    addr2 = 4'd0;
    #1;
    expect_out("untouched_word0", 8'd127, 8'h00, 1'b1, 1'b1);

    // we=0 must block the write.
    @(negedge clk);
    addr1 = 4'd3;
    Min   = 8'hAA;
    we    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    expect_out("we_low_no_write", 8'h00, 8'h00, 1'b1, 1'b0);

    // Old value before the edge, new value right after, no bypass of Min.
    @(negedge clk);
    addr1 = 4'd5;
    addr2 = 4'd5;
    Min   = 8'h3C;
    we    = 1'b1;
    #1;
    expect_out("before_edge", 8'h00, 8'h00, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    expect_out("after_edge", 8'h3C, 8'h3C, 1'b1, 1'b1);
    @(negedge clk);
    we    = 1'b0;
    addr2 = 4'd7;
    #1;
    expect_out("async_addr2_7", 8'h3C, 8'd127, 1'b1, 1'b1);
    addr2 = 4'd8;
    #1;
    expect_out("async_addr2_8", 8'h3C, 8'd255, 1'b1, 1'b1);

    // Clear has priority over a simultaneous write.
    @(negedge clk);
    rst   = 1'b1;
    we    = 1'b1;
    addr1 = 4'd7;
    Min   = 8'h55;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    we  = 1'b0;
    addr2 = 4'd8;
    #1;
    expect_out("reset_priority", 8'h00, 8'h00, 1'b1, 1'b1);
    addr2 = 4'd5;
    #1;
    expect_out("reset_word5", 8'h00, 8'h00, 1'b1, 1'b1);

    // Post-clear write still works on a different address.
    write_word(4'd15, 8'h81);
    addr2 = 4'd15;
    addr1 = 4'd0;
    #1;
    expect_out("write15", 8'h00, 8'h81, 1'b1, 1'b1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_v2.md
Name: memory_v2

Overview:
- Parameterised RAM of 2^K words, each M bits wide.
- One synchronous write port and two independent asynchronous (combinational) read ports.
- Port 1 shares its address with the write port; port 2 is read-only.
- Used as a register-file or scratch memory in datapath experiments. Includes a synchronous clear of the whole array.

Parameters:
- M, 8, word width in bits.
- K, 4, address width in bits; depth = 2^K words (16 by default).

Ports:
- clk  input  1  system clock; all state changes happen on its rising edge.
- rst  input  1  synchronous, active-high reset; clears every word to 0.
- Mout1  output  M  read data port 1 = mem[addr1].
- Mout2  output  M  read data port 2 = mem[addr2].
- Min  input  M  write data.
- we  input  1  write enable, active high.
- addr1  input  K  address for write and for read port 1.
- addr2  input  K  address for read port 2.
- Port order in the instance: Mout1, Mout2, Min, we, clk, addr1, addr2, rst. Connect by name.

Behaviour:
- Storage is an array mem[0 .. 2^K-1] of M-bit words. There is no other state.
- Reset: on a rising clk edge with rst=1, all 2^K words become 0.
  - rst has priority over we; no write occurs in that cycle.
  - Until the first reset, memory contents and outputs are undefined (X). The bench must reset first.
- Write: on a rising clk edge with rst=0 and we=1, mem[addr1] <= Min.
  - No other word changes.
  - If we=0, nothing changes.
- Read: Mout1 = mem[addr1] and Mout2 = mem[addr2], both purely combinational.
  - Address changes are reflected without a clock edge, zero cycle latency.
  - No output registers and no read enable.
- Write-then-read on the same address (port 1 or port 2):
  - Before the edge, outputs show the old contents.
  - Immediately after the edge, they show the newly written value. No bypass of Min before the edge.
- addr1 == addr2: both outputs show the same word.
- All addresses 0 .. 2^K-1 are valid. There is no out-of-range case and no wrap-around logic.
- Write data is taken exactly M bits wide, with no truncation or extension.
- Inputs must be stable around the rising edge. The bench changes stimulus away from posedges, e.g. on negedges.

Test Plan:
- Reset: rst=1 for one posedge, then addr1=0, addr2=15 → Mout1=0, Mout2=0. Repeat with other addresses; every word reads 0.
- Basic write/read: we=1, addr1=7, Min=127, one posedge, then we=0 → Mout1=127 while addr1=7. Set addr2=7 → Mout2=127.
- Second word, full-scale data: we=1, addr1=8, Min=255, posedge, we=0. Then addr1=7 and addr2=8 → Mout1=127, Mout2=255. Then addr2=0 → Mout2=0 (untouched word).
- we=0 blocks writes: addr1=3, Min=0xAA, we=0, posedge → Mout1 stays 0.
- Reset priority: rst=1, we=1, addr1=7, Min=0x55, posedge → Mout1=0, and word 8 also reads 0.
- Combinational read and write timing: with addr2=5 held, write Min=0x3C to addr1=5. Mout2 shows the old value (0) before the edge and 0x3C right after it. Changing addr2 between edges updates Mout2 with no clock.
